// File: rtl/core_lsu_pkg.sv
// Shared encodings and decode helpers for the load/store unit.
package core_lsu_pkg;

   localparam int INSTR_W  = 32;
   localparam int LSU_TO_W = 8;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   // funct3 codes: loads run LB..LWU (0..6), stores run SB..SD (0..3)
   localparam logic [2:0] F3_LOAD_MAX  = 3'd6;
   localparam logic [2:0] F3_STORE_MAX = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   typedef struct packed {
      logic       mem;
      logic       store;
      logic [1:0] size;
      logic       uns;
   } lsu_op_t;

   function automatic lsu_op_t decode_op(input logic [INSTR_W-1:0] instr);
      lsu_op_t op;
      op.store = (instr[6:0] == OP_STORE);
      op.mem   = ((instr[6:0] == OP_LOAD) && (instr[14:12] <= F3_LOAD_MAX)) ||
                 (op.store && (instr[14:12] <= F3_STORE_MAX));
      op.size  = instr[13:12];
      op.uns   = instr[14];
      return op;
   endfunction

   // Low address bits that must be zero for an access of 1 << size bytes.
   function automatic logic [2:0] align_mask(input logic [1:0] size);
      return 3'((4'd1 << size) - 4'd1);
   endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Byte-lane steering: store byte enables and write shift, load shift and extend.
module core_lsu_align
   import core_lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [1:0]      st_size_i,
   input  logic [2:0]      st_off_i,
   input  logic [XLEN-1:0] st_data_i,
   output logic [7:0]      be_o,
   output logic [XLEN-1:0] st_data_o,
   input  logic [1:0]      ld_size_i,
   input  logic [2:0]      ld_off_i,
   input  logic            ld_uns_i,
   input  logic [XLEN-1:0] ld_raw_i,
   output logic [XLEN-1:0] ld_data_o
);

   logic [7:0]      be_mask;
   logic [XLEN-1:0] ld_shift;

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      be_mask   = 8'h00;
      ld_data_o = '0;
      st_data_o = st_data_i << {st_off_i, 3'b000};
      ld_shift  = ld_raw_i >> {ld_off_i, 3'b000};

      unique case (st_size_i)
         2'd0:    be_mask = 8'h01;
         2'd1:    be_mask = 8'h03;
         2'd2:    be_mask = 8'h0F;
         default: be_mask = 8'hFF;
      endcase
      be_o = be_mask << st_off_i;

      unique case (ld_size_i)
         2'd0: ld_data_o = {{(XLEN-8){~ld_uns_i & ld_shift[7]}},   ld_shift[7:0]};
         2'd1: ld_data_o = {{(XLEN-16){~ld_uns_i & ld_shift[15]}}, ld_shift[15:0]};
         2'd2: ld_data_o = {{(XLEN-32){~ld_uns_i & ld_shift[31]}}, ld_shift[31:0]};
         default: ld_data_o = ld_shift;
      endcase
   end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: decodes MEM-stage memory ops and runs the data-memory
// request/grant/response handshake, stalling the pipeline until completion.
module core_lsu
   import core_lsu_pkg::*;
#(
   parameter int XLEN           = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [XLEN-1:0]    addr_i,
   input  logic [XLEN-1:0]    wdata_i,
   output logic               stall_o,
   output logic               done_o,
   output logic [XLEN-1:0]    ld_data_o,
   output logic               misalign_o,
   output logic               bus_err_o,
   output logic               dm_req_o,
   output logic               dm_we_o,
   output logic [XLEN-1:0]    dm_addr_o,
   output logic [XLEN-1:0]    dm_wdata_o,
   output logic [7:0]         dm_be_o,
   input  logic               dm_gnt_i,
   input  logic               dm_rvalid_i,
   input  logic [XLEN-1:0]    dm_rdata_i
);

   lsu_state_e          state_q;
   lsu_op_t             dec;
   logic                store_q, uns_q, bus_err_q;
   logic [1:0]          size_q;
   logic [2:0]          off_q;
   logic [LSU_TO_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]     rdata_q, ld_ext, lane_wdata;
   logic [7:0]          lane_be;
   logic                dm_req_q, dm_we_q;
   logic [XLEN-1:0]     dm_addr_q, dm_wdata_q;
   logic [7:0]          dm_be_q;
   logic                in_idle, busy, aligned, accept, complete, timeout, done;

   assign dec     = decode_op(instr_i);
   assign in_idle = (state_q == ST_IDLE);
   assign busy    = (state_q == ST_REQ) || (state_q == ST_WAIT);
   assign done    = (state_q == ST_DONE);
   assign aligned = (addr_i[2:0] & align_mask(dec.size)) == 3'b000;
   assign accept  = in_idle & valid_i & dec.mem & aligned;

   // A load finishes on rvalid, which may coincide with its grant.
   assign complete = ((state_q == ST_REQ) & dm_gnt_i & (store_q | dm_rvalid_i)) |
                     ((state_q == ST_WAIT) & dm_rvalid_i);
   assign cnt_d    = cnt_q + LSU_TO_W'(1);
   assign timeout  = (cnt_d == LSU_TO_W'(TIMEOUT_CYCLES));

   assign stall_o    = busy | accept;
   assign misalign_o = in_idle & valid_i & dec.mem & ~aligned;
   assign done_o     = done;
   assign bus_err_o  = bus_err_q;
   assign ld_data_o  = (done & ~bus_err_q & ~store_q) ? ld_ext : '0;

   assign dm_req_o   = dm_req_q;
   assign dm_we_o    = dm_we_q;
   assign dm_addr_o  = dm_addr_q;
   assign dm_wdata_o = dm_wdata_q;
   assign dm_be_o    = dm_be_q;

   core_lsu_align #(.XLEN(XLEN)) u_align (
      .st_size_i (dec.size),
      .st_off_i  (addr_i[2:0]),
      .st_data_i (wdata_i),
      .be_o      (lane_be),
      .st_data_o (lane_wdata),
      .ld_size_i (size_q),
      .ld_off_i  (off_q),
      .ld_uns_i  (uns_q),
      .ld_raw_i  (rdata_q),
      .ld_data_o (ld_ext)
   );

   // NOTE: non-blocking assignments only; every signal here is clocked state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         store_q    <= 1'b0;
         uns_q      <= 1'b0;
         size_q     <= '0;
         off_q      <= '0;
         rdata_q    <= '0;
         bus_err_q  <= 1'b0;
         dm_req_q   <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         dm_be_q    <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q    <= ST_REQ;
                  cnt_q      <= '0;
                  store_q    <= dec.store;
                  uns_q      <= dec.uns;
                  size_q     <= dec.size;
                  off_q      <= addr_i[2:0];
                  dm_req_q   <= 1'b1;
                  dm_we_q    <= dec.store;
                  dm_addr_q  <= {addr_i[XLEN-1:3], 3'b000};
                  dm_wdata_q <= lane_wdata;
                  dm_be_q    <= lane_be;
               end
            end
            ST_REQ, ST_WAIT: begin
               cnt_q <= cnt_d;
               // A response in the last allowed cycle still counts as success.
               if (complete) begin
                  rdata_q  <= dm_rdata_i;
                  dm_req_q <= 1'b0;
                  state_q  <= ST_DONE;
               end else if (timeout) begin
                  dm_req_q  <= 1'b0;
                  bus_err_q <= 1'b1;
                  state_q   <= ST_DONE;
               end else if ((state_q == ST_REQ) && dm_gnt_i) begin
                  dm_req_q <= 1'b0;
                  state_q  <= ST_WAIT;
               end
            end
            ST_DONE: begin
               bus_err_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
